// File: rtl/uctl_rst_seq_gen.sv
// Reset-request sequencer: turns power-on, software and USB bus reset causes into
// stretched, staggered per-domain resets with a completion handshake.
module uctl_rst_seq_gen #(
  parameter int NUM_DOM   = 3,
  parameter int STRETCH_W = 8,
  parameter int GAP_CYC   = 4
) (
  input  logic                 clk,
  input  logic                 uctl_rst,
  input  logic                 sw_rst_req,
  input  logic                 bus_rst_req,
  input  logic [STRETCH_W-1:0] stretch_cnt,
  output logic [NUM_DOM-1:0]   dom_rst,
  output logic                 rst_busy,
  output logic                 rst_done,
  output logic [1:0]           rst_src
);

  localparam int GAP_W    = $clog2(NUM_DOM * GAP_CYC + 1);
  localparam int LAST_GAP = (NUM_DOM - 1) * GAP_CYC;

  typedef enum logic [1:0] {IDLE, ASSERT, RELEASE, DONE} state_t;

  state_t               state;
  logic [STRETCH_W-1:0] cnt;
  logic [STRETCH_W-1:0] stretch_q;
  logic [GAP_W-1:0]     gap;
  logic                 bus_q;
  logic                 req;
  logic                 restart;
  logic                 start;
  logic [1:0]           src_new;

  // Inside ASSERT a held bus reset only extends the stretch; only a fresh
  // software request or a new bus-reset edge restarts the count.
  assign req     = sw_rst_req | bus_rst_req;
  assign restart = sw_rst_req | (bus_rst_req & ~bus_q);
  assign start   = (state == ASSERT) ? restart : req;
  assign src_new = bus_rst_req ? 2'b10 : 2'b01;

  // NOTE: all state and outputs update with non-blocking assignments so every
  // branch below reads the pre-edge values, regardless of statement order.
  always_ff @(posedge clk) begin
    bus_q <= bus_rst_req;
    if (uctl_rst) begin
      state     <= ASSERT;
      cnt       <= '0;
      stretch_q <= stretch_cnt;
      gap       <= '0;
      dom_rst   <= '1;
      rst_busy  <= 1'b1;
      rst_done  <= 1'b0;
      rst_src   <= 2'b00;
    end else begin
      rst_done <= 1'b0;
      if (start) begin
        state     <= ASSERT;
        cnt       <= '0;
        stretch_q <= stretch_cnt;
        gap       <= '0;
        dom_rst   <= '1;
        rst_busy  <= 1'b1;
        rst_src   <= src_new;
      end else begin
        case (state)
          IDLE: begin
            dom_rst  <= '0;
            rst_busy <= 1'b0;
          end
          ASSERT: begin
            if (cnt == stretch_q && !bus_rst_req) begin
              state      <= RELEASE;
              gap        <= '0;
              dom_rst[0] <= 1'b0;
            end else if (cnt != stretch_q) begin
              cnt <= cnt + 1'b1;
            end
          end
          RELEASE: begin
            if (gap == GAP_W'(LAST_GAP)) begin
              state    <= DONE;
              rst_done <= 1'b1;
              rst_busy <= 1'b0;
            end else begin
              gap <= gap + 1'b1;
              // Domain i drops on the edge where the gap count reaches i*GAP_CYC.
              for (int i = 1; i < NUM_DOM; i++) begin
                if (int'(gap) + 1 == i * GAP_CYC) dom_rst[i] <= 1'b0;
              end
            end
          end
          DONE: begin
            state <= IDLE;
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uctl_rst_seq_gen.sv
// Directed bench for uctl_rst_seq_gen (NUM_DOM=3, GAP_CYC=4): POR, sw, bus hold,
// restart, abort, simultaneous causes and mid-sequence reset.
module tb_uctl_rst_seq_gen;

  localparam int NUM_DOM   = 3;
  localparam int STRETCH_W = 8;
  localparam int GAP_CYC   = 4;

  logic                 clk = 1'b0;
  logic                 uctl_rst;
  logic                 sw_rst_req;
  logic                 bus_rst_req;
  logic [STRETCH_W-1:0] stretch_cnt;
  logic [NUM_DOM-1:0]   dom_rst;
  logic                 rst_busy;
  logic                 rst_done;
  logic [1:0]           rst_src;

  int n_checks = 0;
  int n_fail   = 0;

  logic [NUM_DOM-1:0] dom_log  [0:39];
  logic               done_log [0:39];
  logic               busy_log [0:39];

  uctl_rst_seq_gen #(
    .NUM_DOM  (NUM_DOM),
    .STRETCH_W(STRETCH_W),
    .GAP_CYC  (GAP_CYC)
  ) dut (
    .clk        (clk),
    .uctl_rst   (uctl_rst),
    .sw_rst_req (sw_rst_req),
    .bus_rst_req(bus_rst_req),
    .stretch_cnt(stretch_cnt),
    .dom_rst    (dom_rst),
    .rst_busy   (rst_busy),
    .rst_done   (rst_done),
    .rst_src    (rst_src)
  );

  always #5 clk = ~clk;

  // Inputs are driven and outputs sampled 1 time unit after each rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic log_cycle(input int j);
    dom_log[j]  = dom_rst;
    done_log[j] = rst_done;
    busy_log[j] = rst_busy;
  endtask

  // Expected outputs relative to r, the log index where dom_rst[0] first drops.
  function automatic logic [NUM_DOM-1:0] exp_dom(input int j, input int r);
    logic [NUM_DOM-1:0] v;
    for (int i = 0; i < NUM_DOM; i++) v[i] = (j < r + i * GAP_CYC);
    return v;
  endfunction

  function automatic logic exp_done(input int j, input int r);
    return (j == r + (NUM_DOM - 1) * GAP_CYC + 1);
  endfunction

  function automatic logic exp_busy(input int j, input int r);
    return (j <= r + (NUM_DOM - 1) * GAP_CYC);
  endfunction

  task automatic test_reset();
    uctl_rst = 1'b1; sw_rst_req = 1'b0; bus_rst_req = 1'b0; stretch_cnt = 8'd4;
    step(); step();
    n_checks += 4;
    if (dom_rst !== 3'b111) begin n_fail++; $display("FAIL reset_dom: got %b want 111", dom_rst); end
    if (rst_busy !== 1'b1) begin n_fail++; $display("FAIL reset_busy: got %b want 1", rst_busy); end
    if (rst_done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", rst_done); end
    if (rst_src !== 2'b00) begin n_fail++; $display("FAIL reset_src: got %b want 00", rst_src); end
    step();
    uctl_rst = 1'b0;
    for (int j = 0; j < 20; j++) begin log_cycle(j); step(); end
    for (int j = 0; j < 20; j++) begin
      n_checks += 3;
      if (dom_log[j] !== exp_dom(j, 5)) begin n_fail++; $display("FAIL por_dom c%0d: got %b want %b", j, dom_log[j], exp_dom(j, 5)); end
      if (done_log[j] !== exp_done(j, 5)) begin n_fail++; $display("FAIL por_done c%0d: got %b want %b", j, done_log[j], exp_done(j, 5)); end
      if (busy_log[j] !== exp_busy(j, 5)) begin n_fail++; $display("FAIL por_busy c%0d: got %b want %b", j, busy_log[j], exp_busy(j, 5)); end
    end
    n_checks++;
    if (rst_src !== 2'b00) begin n_fail++; $display("FAIL por_src: got %b want 00", rst_src); end
  endtask

  task automatic test_sw();
    sw_rst_req = 1'b1; stretch_cnt = 8'd0;
    step();
    sw_rst_req = 1'b0; stretch_cnt = 8'd200;
    for (int j = 0; j < 14; j++) begin log_cycle(j); step(); end
    for (int j = 0; j < 14; j++) begin
      n_checks += 3;
      if (dom_log[j] !== exp_dom(j, 1)) begin n_fail++; $display("FAIL sw_dom k+%0d: got %b want %b", j + 1, dom_log[j], exp_dom(j, 1)); end
      if (done_log[j] !== exp_done(j, 1)) begin n_fail++; $display("FAIL sw_done k+%0d: got %b want %b", j + 1, done_log[j], exp_done(j, 1)); end
      if (busy_log[j] !== exp_busy(j, 1)) begin n_fail++; $display("FAIL sw_busy k+%0d: got %b want %b", j + 1, busy_log[j], exp_busy(j, 1)); end
    end
    n_checks++;
    if (rst_src !== 2'b01) begin n_fail++; $display("FAIL sw_src: got %b want 01", rst_src); end
  endtask

  task automatic test_bus_hold();
    bus_rst_req = 1'b1; stretch_cnt = 8'd2;
    step();
    for (int j = 0; j < 32; j++) begin
      if (j == 19) bus_rst_req = 1'b0;
      log_cycle(j);
      step();
    end
    for (int j = 0; j < 32; j++) begin
      n_checks += 2;
      if (dom_log[j] !== exp_dom(j, 20)) begin n_fail++; $display("FAIL bus_dom k+%0d: got %b want %b", j + 1, dom_log[j], exp_dom(j, 20)); end
      if (done_log[j] !== exp_done(j, 20)) begin n_fail++; $display("FAIL bus_done k+%0d: got %b want %b", j + 1, done_log[j], exp_done(j, 20)); end
    end
    n_checks++;
    if (rst_src !== 2'b10) begin n_fail++; $display("FAIL bus_src: got %b want 10", rst_src); end
  endtask

  task automatic test_restart_in_assert();
    logic [1:0] src_first;
    bus_rst_req = 1'b1; stretch_cnt = 8'd3;
    step();
    bus_rst_req = 1'b0;
    for (int j = 0; j < 20; j++) begin
      sw_rst_req  = (j == 1);
      if (j == 1) stretch_cnt = 8'd5;
      if (j == 2) stretch_cnt = 8'd9;
      log_cycle(j);
      if (j == 0) src_first = rst_src;
      step();
    end
    sw_rst_req = 1'b0;
    n_checks++;
    if (src_first !== 2'b10) begin n_fail++; $display("FAIL restart_src_first: got %b want 10", src_first); end
    for (int j = 0; j < 20; j++) begin
      n_checks += 2;
      if (dom_log[j] !== exp_dom(j, 8)) begin n_fail++; $display("FAIL restart_dom k+%0d: got %b want %b", j + 1, dom_log[j], exp_dom(j, 8)); end
      if (done_log[j] !== exp_done(j, 8)) begin n_fail++; $display("FAIL restart_done k+%0d: got %b want %b", j + 1, done_log[j], exp_done(j, 8)); end
    end
    n_checks++;
    if (rst_src !== 2'b01) begin n_fail++; $display("FAIL restart_src: got %b want 01", rst_src); end
  endtask

  task automatic test_abort_release();
    int r;
    int done_cnt = 0;
    sw_rst_req = 1'b1; stretch_cnt = 8'd1;
    step();
    for (int j = 0; j < 20; j++) begin
      sw_rst_req = (j == 3);
      log_cycle(j);
      step();
    end
    sw_rst_req = 1'b0;
    for (int j = 0; j < 20; j++) begin
      r = (j < 4) ? 2 : 6;
      if (done_log[j] === 1'b1) done_cnt++;
      n_checks += 2;
      if (dom_log[j] !== exp_dom(j, r)) begin n_fail++; $display("FAIL abort_dom k+%0d: got %b want %b", j + 1, dom_log[j], exp_dom(j, r)); end
      if (done_log[j] !== exp_done(j, 6)) begin n_fail++; $display("FAIL abort_done k+%0d: got %b want %b", j + 1, done_log[j], exp_done(j, 6)); end
    end
    n_checks++;
    if (done_cnt != 1) begin n_fail++; $display("FAIL abort_done_count: got %0d want 1", done_cnt); end
  endtask

  task automatic test_simultaneous();
    sw_rst_req = 1'b1; bus_rst_req = 1'b1; stretch_cnt = 8'd0;
    step();
    sw_rst_req = 1'b0; bus_rst_req = 1'b0;
    for (int j = 0; j < 12; j++) begin log_cycle(j); step(); end
    for (int j = 0; j < 12; j++) begin
      n_checks += 2;
      if (dom_log[j] !== exp_dom(j, 1)) begin n_fail++; $display("FAIL simul_dom k+%0d: got %b want %b", j + 1, dom_log[j], exp_dom(j, 1)); end
      if (done_log[j] !== exp_done(j, 1)) begin n_fail++; $display("FAIL simul_done k+%0d: got %b want %b", j + 1, done_log[j], exp_done(j, 1)); end
    end
    n_checks++;
    if (rst_src !== 2'b10) begin n_fail++; $display("FAIL simul_src: got %b want 10", rst_src); end
  endtask

  task automatic test_mid_reset();
    sw_rst_req = 1'b1; stretch_cnt = 8'd0;
    step();
    sw_rst_req = 1'b0;
    step(); step(); step();
    n_checks++;
    if (dom_rst !== 3'b110) begin n_fail++; $display("FAIL midrst_pre_dom: got %b want 110", dom_rst); end
    uctl_rst = 1'b1;
    step();
    n_checks += 4;
    if (dom_rst !== 3'b111) begin n_fail++; $display("FAIL midrst_dom: got %b want 111", dom_rst); end
    if (rst_busy !== 1'b1) begin n_fail++; $display("FAIL midrst_busy: got %b want 1", rst_busy); end
    if (rst_done !== 1'b0) begin n_fail++; $display("FAIL midrst_done: got %b want 0", rst_done); end
    if (rst_src !== 2'b00) begin n_fail++; $display("FAIL midrst_src: got %b want 00", rst_src); end
    uctl_rst = 1'b0;
    for (int j = 0; j < 12; j++) begin log_cycle(j); step(); end
    for (int j = 0; j < 12; j++) begin
      n_checks += 2;
      if (dom_log[j] !== exp_dom(j, 1)) begin n_fail++; $display("FAIL midrst_por_dom c%0d: got %b want %b", j, dom_log[j], exp_dom(j, 1)); end
      if (done_log[j] !== exp_done(j, 1)) begin n_fail++; $display("FAIL midrst_por_done c%0d: got %b want %b", j, done_log[j], exp_done(j, 1)); end
    end
  endtask

  initial begin
    test_reset();
    test_sw();
    test_bus_hold();
    test_restart_in_assert();
    test_abort_release();
    test_simultaneous();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
